// File: rtl/ascii_uint_parser_pkg.sv
// Shared constants, byte classification and FSM state type for the ASCII decimal parser.
package ascii_uint_parser_pkg;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_NL = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic {
      IDLE,
      ACCUM
   } parse_state_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

endpackage

// File: rtl/ascii_uint_parser_if.sv
// Byte-in / record-out handshake bundle; slave is the parser side, master the environment.
interface ascii_uint_parser_if #(
   parameter int unsigned W = 32
);

   logic         s_valid;
   logic         s_ready;
   logic [7:0]   s_data;
   logic         s_last;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_value;
   logic         m_eol;
   logic         m_blank;
   logic         m_overflow;
   logic         m_last;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_value, m_eol, m_blank, m_overflow, m_last
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_value, m_eol, m_blank, m_overflow, m_last
   );

endinterface

// File: rtl/ascii_uint_parser_mul10_add.sv
// Combinational acc*10+d with saturation to all-ones; ovf flags the saturation.
module ascii_uint_parser_mul10_add #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] acc,
   input  logic [3:0]   d,
   output logic [W-1:0] result,
   output logic         ovf
);

   // Four extra bits always hold 10*(2^W-1)+9 without wrapping.
   logic [W+3:0] acc_wide;
   logic [W+3:0] sum;

   assign acc_wide = {4'b0000, acc};
   assign sum      = (acc_wide << 3) + (acc_wide << 1) + {{W{1'b0}}, d};
   assign ovf      = |sum[W+3:W];
   assign result   = ovf ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/ascii_uint_parser.sv
// Streaming ASCII decimal parser: digit runs become W-bit records tagged with line/blank/end flags.
module ascii_uint_parser
   import ascii_uint_parser_pkg::*;
#(
   parameter int unsigned W       = 32,
   parameter bit          SKIP_CR = 1'b1
) (
   input logic                clock,
   input logic                reset,
   ascii_uint_parser_if.slave bus
);

   parse_state_t state;
   logic [W-1:0] acc;
   logic         acc_ovf;
   logic         prev_nl;

   logic         out_valid;
   logic [W-1:0] out_value;
   logic         out_eol;
   logic         out_blank;
   logic         out_ovf;
   logic         out_last;

   logic         accept;
   logic         byte_digit;
   logic         byte_nl;
   logic         byte_skip;
   logic         pending;
   logic         have_num;
   logic [3:0]   digit;
   logic [W-1:0] mac_value;
   logic         mac_ovf;
   logic [W-1:0] num_value;
   logic         num_ovf;

   assign bus.s_ready    = !out_valid || bus.m_ready;
   assign bus.m_valid    = out_valid;
   assign bus.m_value    = out_value;
   assign bus.m_eol      = out_eol;
   assign bus.m_blank    = out_blank;
   assign bus.m_overflow = out_ovf;
   assign bus.m_last     = out_last;

   assign accept     = bus.s_valid && bus.s_ready;
   assign byte_digit = is_digit(bus.s_data);
   assign byte_nl    = (bus.s_data == ASCII_NL);
   assign byte_skip  = SKIP_CR && (bus.s_data == ASCII_CR);
   assign digit      = bus.s_data[3:0];
   assign pending    = (state == ACCUM);
   assign have_num   = pending || byte_digit;

   ascii_uint_parser_mul10_add #(.W(W)) u_mul10_add (
      .acc    (acc),
      .d      (digit),
      .result (mac_value),
      .ovf    (mac_ovf)
   );

   // Number as it stands after this byte (digit folded in if the byte is a digit).
   always_comb begin
      num_value = acc;
      num_ovf   = acc_ovf;
      if (byte_digit) begin
         num_value = pending ? mac_value : W'(digit);
         num_ovf   = pending && (acc_ovf || mac_ovf);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         acc_ovf   <= 1'b0;
         prev_nl   <= 1'b0;
         out_valid <= 1'b0;
         out_value <= '0;
         out_eol   <= 1'b0;
         out_blank <= 1'b0;
         out_ovf   <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (bus.m_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (bus.s_last) begin
               // Final byte always closes out: pending number or a bare end marker.
               out_valid <= 1'b1;
               out_value <= have_num ? num_value : '0;
               out_ovf   <= have_num && num_ovf;
               out_blank <= !have_num;
               out_eol   <= byte_nl;
               out_last  <= 1'b1;
               state     <= IDLE;
               acc       <= '0;
               acc_ovf   <= 1'b0;
               prev_nl   <= 1'b0;
            end else if (!byte_skip) begin
               prev_nl <= byte_nl;
               if (byte_digit) begin
                  state   <= ACCUM;
                  acc     <= num_value;
                  acc_ovf <= num_ovf;
               end else begin
                  state <= IDLE;
                  if (pending || (byte_nl && prev_nl)) begin
                     out_valid <= 1'b1;
                     out_value <= pending ? acc : '0;
                     out_ovf   <= pending && acc_ovf;
                     out_blank <= !pending;
                     out_eol   <= byte_nl;
                     out_last  <= 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule
